// File: rtl/brisc_pkg.sv
// Shared core definitions: machine word width and the skid-register state encoding.
package brisc_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage : brisc_pkg

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: fully registered valid/ready, strict-order payload delivery.
// Optional stall-cycle counter compiled in with PIPE_SKID_PERF_EN.
module pipe_skid_reg
    import brisc_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_d;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_in_fire;
    logic             w_out_fire;

    // Handshake flags come only from the state register, never from inputs.
    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = (r_state != FULL);
    assign out_data   = r_main;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Next-state and data-load decode; flush overrides every handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_main_d    = r_main;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                        w_main_d    = in_data;
                        w_state_nxt = BUSY;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                        w_main_d    = in_data;
                        w_state_nxt = BUSY;
                    end else if (w_in_fire) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_load_main = 1'b1;
                        w_main_d    = r_skid;
                        w_state_nxt = BUSY;
                    end else begin
                        w_state_nxt = FULL;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main payload register: loads only on a firing condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= {WIDTH{1'b0}};
        end else if (w_load_main) begin
            r_main <= w_main_d;
        end
    end

    // Skid register captures the payload that arrives while main is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid <= {WIDTH{1'b0}};
        end else if (w_load_skid) begin
            r_skid <= in_data;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [31:0] r_stall_cnt;

    assign perf_stall_cnt = r_stall_cnt;

    // Saturating count of back-pressured cycles; survives flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (perf counter steps under PIPE_SKID_PERF_EN).
module tb_pipe_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hs(input string tag, input logic ov, input logic ir, input logic [31:0] od);
        check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, ir});
        check({tag, "_out_data"},  out_data, od);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        #1;
        chk_hs("reset", 1'b0, 1'b1, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Streaming with out_ready high: one payload per cycle, latency 1.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        chk_hs("stream0", 1'b1, 1'b1, 32'h11);
        in_data = 32'h22;
        tick();
        chk_hs("stream1", 1'b1, 1'b1, 32'h22);
        in_data = 32'h33;
        tick();
        chk_hs("stream2", 1'b1, 1'b1, 32'h33);
        in_valid = 1'b0;
        tick();
        check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Back-pressure fills the skid entry.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk_hs("bp_busy", 1'b1, 1'b1, 32'hA);
        in_data = 32'hB;
        tick();
        chk_hs("bp_full", 1'b1, 1'b0, 32'hA);
        in_valid = 1'b0;
        in_data  = 32'hEE;
        tick();
        chk_hs("bp_hold", 1'b1, 1'b0, 32'hA);
        out_ready = 1'b1;
        tick();
        chk_hs("bp_pop0", 1'b1, 1'b1, 32'hB);
        tick();
        check("bp_pop1", {31'd0, out_valid}, 32'd0);

        // Flush in FULL discards both entries and the concurrent offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        check("fl_full", {31'd0, in_ready}, 32'd0);
        flush   = 1'b1;
        in_data = 32'h99;
        tick();
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_in_ready",  {31'd0, in_ready},  32'd1);
        flush     = 1'b0;
        in_data   = 32'h55;
        out_ready = 1'b1;
        tick();
        chk_hs("fl_next", 1'b1, 1'b1, 32'h55);
        in_valid = 1'b0;
        tick();
        check("fl_no_stale", {31'd0, out_valid}, 32'd0);

        // Simultaneous in/out fire while BUSY.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h6;
        tick();
        chk_hs("sim_busy", 1'b1, 1'b1, 32'h6);
        in_data   = 32'h7;
        out_ready = 1'b1;
        tick();
        chk_hs("sim_both", 1'b1, 1'b1, 32'h7);
        in_valid = 1'b0;
        tick();
        check("sim_drain", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_PERF_EN
        reset = 1'b1;
        #1;
        check("perf_rst0", perf_stall_cnt, 32'd0);
        reset = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3C;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("perf_cnt10", perf_stall_cnt, 32'd10);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        check("perf_flush", perf_stall_cnt, 32'd10);
        tick();
        reset = 1'b1;
        #1;
        check("perf_rst1", perf_stall_cnt, 32'd0);
        reset = 1'b0;
        tick();
`endif

        // Asynchronous reset between edges while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        tick();
        in_data = 32'h45;
        tick();
        chk_hs("ar_full", 1'b1, 1'b0, 32'h44);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_hs("ar_async", 1'b0, 1'b1, 32'h0);
        #1;
        reset = 1'b0;

        // First posedge after reset release accepts the offer.
        in_valid  = 1'b1;
        in_data   = 32'h77;
        out_ready = 1'b1;
        tick();
        chk_hs("ar_first", 1'b1, 1'b1, 32'h77);
        in_valid = 1'b0;
        tick();
        check("ar_drain", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_skid_reg
